// File: rtl/ngmux_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ngmux_sel_ctrl
// Description : Select controller for the PolarFire NGMUX glitchless clock
//               mux. Runs on a free-running reference clock and drives the
//               mux SEL pin. It watches divide-by-2 toggles from both source
//               domains to decide whether each clock is alive. It accepts
//               switch requests through a valid/ready handshake and can fail
//               over on its own when the selected clock dies.
// Ports       : CLK        - free-running reference clock
//               RESETN     - asynchronous active-low reset
//               CLK0_TOG   - toggle from CLK0 domain (async)
//               CLK1_TOG   - toggle from CLK1 domain (async)
//               REQ_VALID  - switch request valid
//               REQ_SEL    - requested source (0=CLK0, 1=CLK1)
//               REQ_READY  - request can be accepted
//               REQ_DONE   - one-cycle completion pulse
//               REQ_ERR    - qualifies REQ_DONE, 1 = rejected
//               SEL        - NGMUX SEL
//               CLK0_OK    - CLK0 alive
//               CLK1_OK    - CLK1 alive
//               FAILOVER   - one-cycle pulse on automatic switch
//               NO_CLK     - neither source alive
// Revision    : 1.0 - initial release
// ============================================================================
module ngmux_sel_ctrl #(
    parameter int SYNC_STAGES   = 2,
    parameter int WINDOW        = 64,
    parameter int MIN_EDGES     = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int AUTO_FAILOVER = 1
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic CLK0_TOG,
    input  logic CLK1_TOG,
    input  logic REQ_VALID,
    input  logic REQ_SEL,
    output logic REQ_READY,
    output logic REQ_DONE,
    output logic REQ_ERR,
    output logic SEL,
    output logic CLK0_OK,
    output logic CLK1_OK,
    output logic FAILOVER,
    output logic NO_CLK
);

    localparam int c_WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int c_EDGE_W = $clog2(MIN_EDGES + 1);
    localparam int c_SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [c_WIN_W-1:0]  c_WIN_LAST = c_WIN_W'(WINDOW - 1);
    localparam logic [c_EDGE_W-1:0] c_EDGE_MAX = c_EDGE_W'(MIN_EDGES);
    localparam logic [c_SET_W-1:0]  c_SET_LAST = c_SET_W'(SETTLE_CYCLES - 1);
    localparam logic                c_AUTO     = (AUTO_FAILOVER != 0);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_SETTLE = 1'b1;

    // ------------------------------------------------------------------
    // Toggle synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync0;
    logic [SYNC_STAGES-1:0] r_sync1;
    logic                   w_edge0;
    logic                   w_edge1;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_sync0 <= '0;
            r_sync1 <= '0;
        end else begin
            r_sync0 <= {r_sync0[SYNC_STAGES-2:0], CLK0_TOG};
            r_sync1 <= {r_sync1[SYNC_STAGES-2:0], CLK1_TOG};
        end
    end

    // Either polarity of the toggle counts as one source-clock activity edge.
    assign w_edge0 = r_sync0[SYNC_STAGES-1] ^ r_sync0[SYNC_STAGES-2];
    assign w_edge1 = r_sync1[SYNC_STAGES-1] ^ r_sync1[SYNC_STAGES-2];

    // ------------------------------------------------------------------
    // Activity window: saturating edge counters, OK flags, NO_CLK
    // ------------------------------------------------------------------
    logic [c_WIN_W-1:0]  r_win;
    logic [c_EDGE_W-1:0] r_cnt0;
    logic [c_EDGE_W-1:0] r_cnt1;
    logic                r_clk0_ok;
    logic                r_clk1_ok;
    logic                r_no_clk;
    logic                r_ok0_prev;
    logic                r_ok1_prev;
    logic                w_wrap;
    logic                w_ok0_new;
    logic                w_ok1_new;

    // On the wrap cycle the counter restarts with that cycle's edge so no
    // edge is lost between windows.
    function automatic logic [c_EDGE_W-1:0] f_cnt_next(
        input logic [c_EDGE_W-1:0] cnt,
        input logic                e,
        input logic                wrap
    );
        logic [c_EDGE_W-1:0] v;
        v = cnt;
        if (wrap) begin
            v    = '0;
            v[0] = e;
        end else if (e && (cnt != c_EDGE_MAX)) begin
            v = cnt + 1'b1;
        end
        return v;
    endfunction

    assign w_wrap    = (r_win == c_WIN_LAST);
    assign w_ok0_new = (r_cnt0 >= c_EDGE_MAX);
    assign w_ok1_new = (r_cnt1 >= c_EDGE_MAX);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_win      <= '0;
            r_cnt0     <= '0;
            r_cnt1     <= '0;
            r_clk0_ok  <= 1'b0;
            r_clk1_ok  <= 1'b0;
            r_no_clk   <= 1'b0;
            r_ok0_prev <= 1'b0;
            r_ok1_prev <= 1'b0;
        end else begin
            r_win      <= w_wrap ? '0 : r_win + 1'b1;
            r_cnt0     <= f_cnt_next(r_cnt0, w_edge0, w_wrap);
            r_cnt1     <= f_cnt_next(r_cnt1, w_edge1, w_wrap);
            r_ok0_prev <= r_clk0_ok;
            r_ok1_prev <= r_clk1_ok;
            // NO_CLK tracks the OK flags from the first window end onward;
            // updating it on the wrap keeps it aligned with the flags.
            if (w_wrap) begin
                r_clk0_ok <= w_ok0_new;
                r_clk1_ok <= w_ok1_new;
                r_no_clk  <= !w_ok0_new && !w_ok1_new;
            end
        end
    end

    // ------------------------------------------------------------------
    // Selection FSM
    // ------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [c_SET_W-1:0] r_set_cnt;
    logic               r_sel;
    logic               r_ready;
    logic               r_done;
    logic               r_err;
    logic               r_failover;
    logic               r_pend;     // settle was started by a request
    logic               r_recheck;  // first IDLE cycle after a settle

    logic [0:0]         w_state_next;
    logic [c_SET_W-1:0] w_set_cnt_next;
    logic               w_sel_next;
    logic               w_done_next;
    logic               w_err_next;
    logic               w_fo_next;
    logic               w_pend_next;
    logic               w_recheck_next;
    logic               w_active_ok;
    logic               w_active_prev;
    logic               w_other_ok;
    logic               w_target_ok;
    logic               w_loss_evt;
    logic               w_fail_cond;
    logic               w_accept;

    assign w_active_ok   = r_sel ? r_clk1_ok  : r_clk0_ok;
    assign w_active_prev = r_sel ? r_ok1_prev : r_ok0_prev;
    assign w_other_ok    = r_sel ? r_clk0_ok  : r_clk1_ok;
    assign w_target_ok   = REQ_SEL ? r_clk1_ok : r_clk0_ok;
    assign w_loss_evt    = w_active_prev && !w_active_ok;
    // A loss seen during SETTLE is caught by the level check on return.
    assign w_fail_cond   = c_AUTO && !w_active_ok && w_other_ok &&
                           (w_loss_evt || r_recheck);
    assign w_accept      = REQ_VALID && r_ready && (r_state == c_ST_IDLE);

    always_comb begin
        w_state_next   = r_state;
        w_set_cnt_next = r_set_cnt;
        w_sel_next     = r_sel;
        w_done_next    = 1'b0;
        w_err_next     = 1'b0;
        w_fo_next      = 1'b0;
        w_pend_next    = r_pend;
        w_recheck_next = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_fail_cond) begin
                    w_sel_next     = !r_sel;
                    w_fo_next      = 1'b1;
                    w_state_next   = c_ST_SETTLE;
                    w_set_cnt_next = '0;
                    w_pend_next    = 1'b0;
                    // A request colliding with a failover is rejected.
                    if (w_accept) begin
                        w_done_next = 1'b1;
                        w_err_next  = 1'b1;
                    end
                end else if (w_accept) begin
                    if (REQ_SEL == r_sel) begin
                        w_done_next = 1'b1;
                    end else if (!w_target_ok) begin
                        w_done_next = 1'b1;
                        w_err_next  = 1'b1;
                    end else begin
                        w_sel_next     = REQ_SEL;
                        w_state_next   = c_ST_SETTLE;
                        w_set_cnt_next = '0;
                        w_pend_next    = 1'b1;
                    end
                end
            end
            default: begin
                if (r_set_cnt == c_SET_LAST) begin
                    w_state_next   = c_ST_IDLE;
                    w_done_next    = r_pend;
                    w_pend_next    = 1'b0;
                    w_recheck_next = 1'b1;
                end else begin
                    w_set_cnt_next = r_set_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state    <= c_ST_IDLE;
            r_set_cnt  <= '0;
            r_sel      <= 1'b0;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_failover <= 1'b0;
            r_pend     <= 1'b0;
            r_recheck  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_set_cnt  <= w_set_cnt_next;
            r_sel      <= w_sel_next;
            r_ready    <= (w_state_next == c_ST_IDLE);
            r_done     <= w_done_next;
            r_err      <= w_err_next;
            r_failover <= w_fo_next;
            r_pend     <= w_pend_next;
            r_recheck  <= w_recheck_next;
        end
    end

    assign REQ_READY = r_ready;
    assign REQ_DONE  = r_done;
    assign REQ_ERR   = r_err;
    assign SEL       = r_sel;
    assign CLK0_OK   = r_clk0_ok;
    assign CLK1_OK   = r_clk1_ok;
    assign FAILOVER  = r_failover;
    assign NO_CLK    = r_no_clk;

endmodule
`default_nettype wire
